pong_speed_controller: RTL and testbench
========================================

Name: pong_speed_controller

Overview:
Game-flow and speed scheduler for PONG. It sequences serve / play / pause / game-over and drives the 4-bit `level` input of clock_generator. Ball speed rises with rally length and drops back after each miss. It sits between the ball/paddle collision logic and clock_generator, and gates ball motion through `run`.

Parameters:
HITS_PER_LEVEL, 4, paddle hits per level increment (>=1)
START_LEVEL, 1, level after reset, miss or new game (0..15)
MAX_LEVEL, 15, saturation ceiling for level (START_LEVEL..15)
PAUSE_TICKS, 60, frame ticks spent in PAUSE after a miss (>=1)
LIVES, 3, misses allowed per game (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse from start button (debounced upstream)
frame_tick  in  1  1-cycle pulse per video frame
paddle_hit  in  1  1-cycle pulse, ball struck a paddle
ball_miss  in  1  1-cycle pulse, ball passed a paddle
level  out  4  speed level to clock_generator.level
run  out  1  ball/paddle motion enable
serve  out  1  1-cycle pulse, re-centre ball and launch
lives_left  out  4  remaining lives
game_over  out  1  high while in OVER
state  out  3  FSM state: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4

Behaviour:
- All outputs are registered. Every reset effect is visible on the first clk edge with reset=1.
- Reset values, which also apply when reset is asserted mid-game: state=IDLE, level=START_LEVEL, lives_left=LIVES, run=0, serve=0, game_over=0. Internal hit_cnt=0 and pause_cnt=0.
- IDLE: run=0. start -> SERVE. All other inputs are ignored.
- SERVE: lasts exactly 1 cycle with serve=1, then goes unconditionally to PLAY. serve=0 in every other state.
- PLAY: run=1.
  - On paddle_hit: if hit_cnt==HITS_PER_LEVEL-1, set hit_cnt=0 and level=min(level+1, MAX_LEVEL). Otherwise hit_cnt+1.
  - On ball_miss: lives_left-1, level=START_LEVEL, hit_cnt=0.
    - If lives_left was 1 -> OVER.
    - Otherwise -> PAUSE with pause_cnt=PAUSE_TICKS.
  - paddle_hit and ball_miss in the same cycle: miss wins and the hit is discarded.
  - Once level is at MAX_LEVEL, further hits still cycle hit_cnt but level does not change.
- PAUSE: run=0.
  - On frame_tick, pause_cnt-1. A frame_tick while pause_cnt==1 -> SERVE.
  - PAUSE lasts exactly PAUSE_TICKS frame ticks. paddle_hit, ball_miss and start are ignored.
- OVER: game_over=1, run=0, and level/lives_left hold their values.
  - On start: lives_left=LIVES, level=START_LEVEL, hit_cnt=0 -> SERVE. game_over drops in the same edge.
- start is ignored in SERVE, PLAY and PAUSE.
- frame_tick is ignored outside PAUSE.
- level changes only on clk edges. clock_generator sees a new value one cycle after the causing pulse.
- Width rules:
  - lives_left never underflows, because the transition to OVER happens at 1.
  - level never exceeds MAX_LEVEL.
  - Counters are 4-bit (hit_cnt) and 8-bit (pause_cnt).
- Undefined state encodings recover to IDLE on the next edge.

Decomposition:
- Shared include pong_defs.vh: state encodings (ST_IDLE..ST_OVER), the level width constant (4), and the START_LEVEL/MAX_LEVEL defaults shared with clock_generator.
- One natural sub-module: pong_pause_timer. It is a loadable down-counter with parameterised width, `load` / `tick` inputs and a `done` pulse output, reused later for an attract-mode timeout.
- The FSM, hit counter and level register stay in the top module.

Test Plan:
- reset high 2 cycles then low -> state=0, level=1, lives_left=3, run=0, serve=0, game_over=0.
- start pulse from IDLE -> next edge state=1 with serve=1 for exactly 1 cycle, then state=2 with run=1.
- In PLAY, 4 paddle_hit pulses -> level=2 one cycle after the 4th. Then 52 further hits -> level saturates at 15 and stays 15 on more hits.
- In PLAY at level=5, paddle_hit and ball_miss in the same cycle -> level=1, lives_left=2, state=3. Then 60 frame_ticks -> SERVE exactly after the 60th tick, and serve pulses once. Hits issued during PAUSE do not change level.
- Three misses across a game -> lives_left=0, state=4, game_over=1, run=0. start -> lives_left=3, level=1, state=1, game_over=0.
- Assert reset for 1 cycle mid-PAUSE with pause_cnt=30 -> all reset values. A following frame_tick causes no transition, and state stays IDLE.

Source files
------------

// File: rtl/pong_speed_controller_pkg.sv
// rtl/pong_speed_controller_pkg.sv - shared state encodings and level defaults for the PONG speed path
package pong_speed_controller_pkg;

   localparam int LEVEL_W         = 4;
   localparam int DEF_START_LEVEL = 1;
   localparam int DEF_MAX_LEVEL   = 15;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

endpackage

// File: rtl/pong_pause_timer.sv
// rtl/pong_pause_timer.sv - loadable down-counter, done pulses on the tick that empties it
module pong_pause_timer #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_tick,
   output logic         o_done
);

   localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - C_ONE;
      end
   end

   // Combinational so the owner can act on the same edge as the final tick.
   assign o_done = i_tick && !i_load && (r_count == C_ONE);

endmodule

// File: rtl/pong_speed_controller.sv
// rtl/pong_speed_controller.sv - serve/play/pause/over sequencing and ball speed level for PONG
module pong_speed_controller
   import pong_speed_controller_pkg::*;
#(
   parameter int HITS_PER_LEVEL = 4,
   parameter int START_LEVEL    = DEF_START_LEVEL,
   parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
   parameter int PAUSE_TICKS    = 60,
   parameter int LIVES          = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_frame_tick,
   input  logic               i_paddle_hit,
   input  logic               i_ball_miss,
   output logic [LEVEL_W-1:0] o_level,
   output logic               o_run,
   output logic               o_serve,
   output logic [3:0]         o_lives_left,
   output logic               o_game_over,
   output logic [2:0]         o_state
);

   localparam logic [LEVEL_W-1:0] C_START    = LEVEL_W'(START_LEVEL);
   localparam logic [LEVEL_W-1:0] C_MAX      = LEVEL_W'(MAX_LEVEL);
   localparam logic [3:0]         C_HIT_LAST = 4'(HITS_PER_LEVEL - 1);
   localparam logic [3:0]         C_LIVES    = 4'(LIVES);
   localparam logic [7:0]         C_PAUSE    = 8'(PAUSE_TICKS);

   logic [2:0]         r_state;
   logic [LEVEL_W-1:0] r_level;
   logic [3:0]         r_lives;
   logic [3:0]         r_hit_cnt;
   logic               r_run;
   logic               r_serve;
   logic               r_game_over;

   logic [2:0] w_next;
   logic       w_load;
   logic       w_hit;
   logic       w_miss;
   logic       w_restart;
   logic       w_tick;
   logic       w_done;

   assign w_tick = i_frame_tick && (r_state == ST_PAUSE);

   pong_pause_timer #(
      .W(8)
   ) u_pause_timer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_load),
      .i_load_val (C_PAUSE),
      .i_tick     (w_tick),
      .o_done     (w_done)
   );

   always_comb begin
      w_next    = ST_IDLE;
      w_load    = 1'b0;
      w_hit     = 1'b0;
      w_miss    = 1'b0;
      w_restart = 1'b0;
      case (r_state)
         ST_IDLE:  w_next = i_start ? ST_SERVE : ST_IDLE;
         ST_SERVE: w_next = ST_PLAY;
         ST_PLAY: begin
            w_next = ST_PLAY;
            // A miss in the same cycle as a hit swallows the hit.
            if (i_ball_miss) begin
               w_miss = 1'b1;
               if (r_lives == 4'd1) begin
                  w_next = ST_OVER;
               end else begin
                  w_next = ST_PAUSE;
                  w_load = 1'b1;
               end
            end else if (i_paddle_hit) begin
               w_hit = 1'b1;
            end
         end
         ST_PAUSE: w_next = w_done ? ST_SERVE : ST_PAUSE;
         ST_OVER: begin
            w_next = ST_OVER;
            if (i_start) begin
               w_next    = ST_SERVE;
               w_restart = 1'b1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Status flags decode the next state so they line up with o_state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_run       <= 1'b0;
         r_serve     <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_run       <= (w_next == ST_PLAY);
         r_serve     <= (w_next == ST_SERVE);
         r_game_over <= (w_next == ST_OVER);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_level   <= C_START;
         r_lives   <= C_LIVES;
         r_hit_cnt <= '0;
      end else if (w_miss) begin
         r_level   <= C_START;
         r_lives   <= r_lives - 4'd1;
         r_hit_cnt <= '0;
      end else if (w_restart) begin
         r_level   <= C_START;
         r_lives   <= C_LIVES;
         r_hit_cnt <= '0;
      end else if (w_hit) begin
         if (r_hit_cnt == C_HIT_LAST) begin
            r_hit_cnt <= '0;
            if (r_level < C_MAX) begin
               r_level <= r_level + 1'b1;
            end
         end else begin
            r_hit_cnt <= r_hit_cnt + 4'd1;
         end
      end
   end

   assign o_state      = r_state;
   assign o_level      = r_level;
   assign o_lives_left = r_lives;
   assign o_run        = r_run;
   assign o_serve      = r_serve;
   assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_pong_speed_controller.sv
// tb/tb_pong_speed_controller.sv - directed bench with a game-rules model checked every cycle
module tb_pong_speed_controller;

   localparam int HPL   = 4;
   localparam int START = 1;
   localparam int MAXL  = 15;
   localparam int PT    = 60;
   localparam int LIV   = 3;

   logic       clk = 1'b0;
   logic       reset, start, frame_tick, paddle_hit, ball_miss;
   logic [3:0] level, lives_left;
   logic       run, serve, game_over;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   int m_state, m_level, m_lives, m_hits, m_pause;
   bit m_valid = 1'b0;

   pong_speed_controller #(
      .HITS_PER_LEVEL(HPL), .START_LEVEL(START), .MAX_LEVEL(MAXL),
      .PAUSE_TICKS(PT), .LIVES(LIV)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_frame_tick(frame_tick),
      .i_paddle_hit(paddle_hit), .i_ball_miss(ball_miss),
      .o_level(level), .o_run(run), .o_serve(serve), .o_lives_left(lives_left),
      .o_game_over(game_over), .o_state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Game rules: a miss costs a life and the speed; enough hits in a row earn a level.
   always @(posedge clk) begin
      int s, l, v, h, p;
      s = m_state; l = m_level; v = m_lives; h = m_hits; p = m_pause;
      if (reset) begin
         s = 0; l = START; v = LIV; h = 0; p = 0;
      end else if (s == 0) begin
         if (start) s = 1;
      end else if (s == 1) begin
         s = 2;
      end else if (s == 2) begin
         if (ball_miss) begin
            v = v - 1; l = START; h = 0;
            if (v == 0) s = 4;
            else begin s = 3; p = PT; end
         end else if (paddle_hit) begin
            h = h + 1;
            if (h == HPL) begin
               h = 0;
               if (l < MAXL) l = l + 1;
            end
         end
      end else if (s == 3) begin
         if (frame_tick) begin
            p = p - 1;
            if (p == 0) s = 1;
         end
      end else if (s == 4) begin
         if (start) begin s = 1; v = LIV; l = START; h = 0; end
      end
      m_state <= s; m_level <= l; m_lives <= v; m_hits <= h; m_pause <= p;
      if (reset) m_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         n_checks++;
         if ({state, level, lives_left, run, serve, game_over} !==
             {3'(m_state), 4'(m_level), 4'(m_lives), m_state == 2, m_state == 1, m_state == 4}) begin
            n_fail++;
            $display("FAIL cycle: got st=%0d lvl=%0d lives=%0d run=%0d serve=%0d over=%0d expected st=%0d lvl=%0d lives=%0d at %0t",
                     state, level, lives_left, run, serve, game_over, m_state, m_level, m_lives, $time);
         end
      end
   end

   task automatic step(input bit r, input bit s, input bit f, input bit h, input bit m);
      reset = r; start = s; frame_tick = f; paddle_hit = h; ball_miss = m;
      @(negedge clk);
      reset = 0; start = 0; frame_tick = 0; paddle_hit = 0; ball_miss = 0;
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 0, 1, 0);
         step(0, 0, 0, 0, 0);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 1, 0, 0);
         step(0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      reset = 1; start = 0; frame_tick = 0; paddle_hit = 0; ball_miss = 0;
      @(negedge clk);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset_state", state, 0);
      chk("reset_level", level, 1);
      chk("reset_lives", lives_left, 3);
      chk("reset_flags", {run, serve, game_over}, 0);

      step(0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 0);
      chk("idle_ignores", state, 0);

      step(0, 1, 0, 0, 0);
      chk("serve_state", state, 1);
      chk("serve_pulse", serve, 1);
      step(0, 1, 0, 0, 0);
      chk("play_state", state, 2);
      chk("play_run", run, 1);
      chk("serve_drop", serve, 0);

      hits(4);
      chk("level_after_4", level, 2);
      hits(12);
      chk("level_5", level, 5);

      step(0, 0, 0, 1, 1);
      chk("miss_wins_level", level, 1);
      chk("miss_wins_lives", lives_left, 2);
      chk("miss_pause", state, 3);
      chk("pause_run", run, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 1);
      chk("pause_ignores_hit", level, 1);
      chk("pause_ignores_miss", lives_left, 2);

      ticks(59);
      chk("pause_59", state, 3);
      step(0, 0, 1, 0, 0);
      chk("pause_60_serve", state, 1);
      chk("pause_60_pulse", serve, 1);
      step(0, 0, 0, 0, 0);
      chk("back_to_play", state, 2);

      hits(56);
      chk("level_sat", level, 15);
      hits(5);
      chk("level_stays_sat", level, 15);

      step(0, 0, 0, 0, 1);
      chk("miss2_lives", lives_left, 1);
      ticks(60);
      chk("play_again", state, 2);
      step(0, 0, 1, 0, 1);
      chk("over_state", state, 4);
      chk("over_lives", lives_left, 0);
      chk("over_flag", game_over, 1);
      chk("over_run", run, 0);
      hits(2);
      ticks(2);
      chk("over_holds", state, 4);
      chk("over_level_hold", level, 1);

      step(0, 1, 0, 0, 0);
      chk("restart_lives", lives_left, 3);
      chk("restart_level", level, 1);
      chk("restart_state", state, 1);
      chk("restart_over", game_over, 0);
      step(0, 0, 0, 0, 0);
      hits(7);
      chk("restart_hits", level, 2);

      step(0, 0, 0, 0, 1);
      ticks(30);
      chk("mid_pause", state, 3);
      step(1, 0, 0, 0, 0);
      chk("midreset_state", state, 0);
      chk("midreset_level", level, 1);
      chk("midreset_lives", lives_left, 3);
      chk("midreset_flags", {run, serve, game_over}, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("tick_after_reset", state, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
